// File: rtl/train_pkg.sv
// Shared types and helpers for the train route sequencer.
package train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_JUNC,
        ST_POST,
        ST_END
    } train_state_e;

    localparam logic TRACK_MAIN   = 1'b0;
    localparam logic TRACK_SIDING = 1'b1;

    // Bits needed to index n distinct values (n >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/train_route_seq_if.sv
// Request/status bundle between the debouncer side and the motor/LED side of the sequencer.
interface train_route_seq_if #(
    parameter int STEP_W = 4
);
    logic              adv;
    logic              route;
    logic [STEP_W-1:0] pos;
    logic              track;
    logic              depart;
    logic              at_junc;
    logic              at_end;
    logic              busy;
    logic              fault;

    modport master (
        output adv, route,
        input  pos, track, depart, at_junc, at_end, busy, fault
    );

    modport slave (
        input  adv, route,
        output pos, track, depart, at_junc, at_end, busy, fault
    );
endinterface

// File: rtl/train_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and fires a one-cycle trip at WDOG_CYC.
import train_pkg::*;

module train_wdog #(
    parameter int WDOG_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic trip,
    output logic fault
);
    localparam int              CNT_W = clog2(WDOG_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Trip on the stalled cycle that would bring the count to WDOG_CYC.
    assign trip = stall && (cnt_q == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            fault <= 1'b0;
        end else begin
            fault <= trip;
            if (!stall || trip) cnt_q <= '0;
            else                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/train_route_seq.sv
// Track-sequence controller: depart -> junction (route latch) -> main/siding end stop -> idle.
// Optional stall watchdog enabled with `define TRAIN_SEQ_WDOG_EN.
import train_pkg::*;

module train_route_seq #(
    parameter int PRE_STEPS  = 6,
    parameter int POST_STEPS = 4,
    parameter int STEP_W     = 4,
    parameter int WDOG_CYC   = 255
) (
    input logic               clk,
    input logic               rst_n,
    train_route_seq_if.slave  bus
);
    localparam logic [STEP_W-1:0] JUNC_POS = STEP_W'(PRE_STEPS);
    localparam logic [STEP_W-1:0] END_POS  = STEP_W'(PRE_STEPS + POST_STEPS);

    if (clog2(PRE_STEPS + POST_STEPS + 1) > STEP_W) begin : g_bad_step_w
        $error("STEP_W too small for PRE_STEPS+POST_STEPS");
    end
    if (PRE_STEPS < 1 || POST_STEPS < 1) begin : g_bad_steps
        $error("PRE_STEPS and POST_STEPS must be >= 1");
    end
    if (WDOG_CYC < 1) begin : g_bad_wdog
        $error("WDOG_CYC must be >= 1");
    end

    train_state_e      state_q, state_d;
    logic [STEP_W-1:0] pos_q, pos_d;
    logic              track_q, track_d;
    logic              depart_q, depart_d;
    logic              wdog_trip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            track_q  <= TRACK_MAIN;
            depart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            track_q  <= track_d;
            depart_q <= depart_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        track_d  = track_q;
        depart_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.adv) begin
                    pos_d    = STEP_W'(1);
                    depart_d = 1'b1;
                    state_d  = (PRE_STEPS == 1) ? ST_JUNC : ST_PRE;
                end
            end
            ST_PRE: begin
                if (bus.adv) begin
                    pos_d = pos_q + STEP_W'(1);
                    if (pos_d == JUNC_POS) state_d = ST_JUNC;
                end
            end
            ST_JUNC: begin
                // Route is only sampled while parked; the departing edge keeps the held track.
                if (bus.adv) begin
                    pos_d   = pos_q + STEP_W'(1);
                    state_d = (POST_STEPS == 1) ? ST_END : ST_POST;
                end else begin
                    track_d = bus.route;
                end
            end
            ST_POST: begin
                if (bus.adv) begin
                    pos_d = pos_q + STEP_W'(1);
                    if (pos_d == END_POS) state_d = ST_END;
                end
            end
            ST_END: begin
                if (!bus.adv) begin
                    pos_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                pos_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (wdog_trip) begin
            pos_d    = '0;
            state_d  = ST_IDLE;
            depart_d = 1'b0;
        end
    end

`ifdef TRAIN_SEQ_WDOG_EN
    logic stall;
    logic fault_q;

    // END is exempt: parking at the stop is legal.
    assign stall = !bus.adv &&
                   (state_q == ST_PRE || state_q == ST_JUNC || state_q == ST_POST);

    train_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .trip  (wdog_trip),
        .fault (fault_q)
    );

    assign bus.fault = fault_q;
`else
    assign wdog_trip = 1'b0;
    assign bus.fault = 1'b0;
`endif

    assign bus.pos     = pos_q;
    assign bus.track   = track_q;
    assign bus.depart  = depart_q;
    assign bus.at_junc = (pos_q == JUNC_POS);
    assign bus.at_end  = (pos_q == END_POS);
    assign bus.busy    = (pos_q != '0);
endmodule

// File: tb/tb_train_route_seq.sv
// Directed bench for train_route_seq with a position-level reference model checked every cycle.
module tb_train_route_seq;

`ifdef TRAIN_SEQ_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    typedef struct {
        int pos;
        bit track;
        bit depart;
        bit fault;
        int stall;
    } model_t;

    logic clk;
    logic rst_n;
    bit   chk_en;
    int   n_tests;
    int   n_fail;

    model_t ma, mb;

    train_route_seq_if #(.STEP_W(4)) ifa ();
    train_route_seq_if #(.STEP_W(2)) ifb ();

    train_route_seq #(.PRE_STEPS(6), .POST_STEPS(4), .STEP_W(4), .WDOG_CYC(255)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    train_route_seq #(.PRE_STEPS(1), .POST_STEPS(1), .STEP_W(2), .WDOG_CYC(255)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

`ifdef TRAIN_SEQ_WDOG_EN
    model_t mc;
    train_route_seq_if #(.STEP_W(4)) ifc ();
    train_route_seq #(.PRE_STEPS(6), .POST_STEPS(4), .STEP_W(4), .WDOG_CYC(8)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one move per accepted adv, parked at junction latches route, watchdog on stalls.
    function automatic model_t step(model_t m, bit adv, bit route, int pre, int post,
                                    int wcyc, bit wen);
        model_t n;
        int     endp;
        n        = m;
        endp     = pre + post;
        n.depart = 1'b0;
        n.fault  = 1'b0;
        if (m.pos == 0) begin
            if (adv) begin
                n.pos    = 1;
                n.depart = 1'b1;
            end
        end else if (m.pos == endp) begin
            if (!adv) n.pos = 0;
        end else if (adv) begin
            n.pos = m.pos + 1;
        end else if (m.pos == pre) begin
            n.track = route;
        end
        if (wen) begin
            if (m.pos != 0 && m.pos != endp && !adv) begin
                n.stall = m.stall + 1;
                if (n.stall >= wcyc) begin
                    n.pos   = 0;
                    n.fault = 1'b1;
                    n.stall = 0;
                end
            end else begin
                n.stall = 0;
            end
        end
        return n;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.pos = 0; m.track = 1'b0; m.depart = 1'b0; m.fault = 1'b0; m.stall = 0;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= model_reset();
            mb <= model_reset();
`ifdef TRAIN_SEQ_WDOG_EN
            mc <= model_reset();
`endif
        end else begin
            ma <= step(ma, ifa.adv, ifa.route, 6, 4, 255, WDOG);
            mb <= step(mb, ifb.adv, ifb.route, 1, 1, 255, WDOG);
`ifdef TRAIN_SEQ_WDOG_EN
            mc <= step(mc, ifc.adv, ifc.route, 6, 4, 8, 1'b1);
`endif
        end
    end

    task automatic cmp(input string nm, input model_t m, input int pre, input int post,
                       input int pos, input bit trk, input bit dep, input bit jn,
                       input bit en, input bit bsy, input bit flt);
        n_tests++;
        if (pos != m.pos || trk != m.track || dep != m.depart || jn != (m.pos == pre) ||
            en != (m.pos == pre + post) || bsy != (m.pos != 0) || flt != m.fault) begin
            n_fail++;
            $display("FAIL %s t=%0t: dut pos=%0d trk=%0d dep=%0d jn=%0d end=%0d busy=%0d flt=%0d; model pos=%0d trk=%0d dep=%0d flt=%0d",
                     nm, $time, pos, trk, dep, jn, en, bsy, flt,
                     m.pos, m.track, m.depart, m.fault);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_a", ma, 6, 4, int'(ifa.pos), ifa.track, ifa.depart, ifa.at_junc,
                ifa.at_end, ifa.busy, ifa.fault);
            cmp("model_b", mb, 1, 1, int'(ifb.pos), ifb.track, ifb.depart, ifb.at_junc,
                ifb.at_end, ifb.busy, ifb.fault);
`ifdef TRAIN_SEQ_WDOG_EN
            cmp("model_c", mc, 6, 4, int'(ifc.pos), ifc.track, ifc.depart, ifc.at_junc,
                ifc.at_end, ifc.busy, ifc.fault);
`endif
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input int w, input bit a, input bit r);
        case (w)
            0: begin ifa.adv = a; ifa.route = r; end
            1: begin ifb.adv = a; ifb.route = r; end
`ifdef TRAIN_SEQ_WDOG_EN
            2: begin ifc.adv = a; ifc.route = r; end
`endif
            default: ;
        endcase
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        ifa.adv = 1'b0; ifa.route = 1'b0;
        ifb.adv = 1'b0; ifb.route = 1'b0;
`ifdef TRAIN_SEQ_WDOG_EN
        ifc.adv = 1'b0; ifc.route = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_pos", int'(ifa.pos), 0);
        chk("rst_track", int'(ifa.track), 0);
        chk("rst_depart", int'(ifa.depart), 0);
        chk("rst_fault", int'(ifa.fault), 0);

        // Full run on main track.
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 1'b1, 1'b0);
            chk("run_pos", int'(ifa.pos), (i < 10) ? i : 10);
            chk("run_depart", int'(ifa.depart), (i == 1) ? 1 : 0);
            chk("run_at_end", int'(ifa.at_end), (i >= 10) ? 1 : 0);
        end
        chk("run_track", int'(ifa.track), 0);
        cyc(0, 1'b0, 1'b0);
        chk("run_back_idle", int'(ifa.pos), 0);
        chk("run_busy_off", int'(ifa.busy), 0);

        // Hold in PRE, then park at junction and latch route.
        repeat (3) cyc(0, 1'b1, 1'b0);
        repeat (2) cyc(0, 1'b0, 1'b0);
        chk("pre_hold_pos", int'(ifa.pos), 3);
        cyc(0, 1'b1, 1'b0);
        chk("pre_resume_pos", int'(ifa.pos), 4);
        repeat (2) cyc(0, 1'b1, 1'b0);
        chk("junc_pos", int'(ifa.pos), 6);
        chk("junc_flag", int'(ifa.at_junc), 1);
        cyc(0, 1'b0, 1'b0);
        chk("junc_route0", int'(ifa.track), 0);
        cyc(0, 1'b0, 1'b1);
        chk("junc_route1", int'(ifa.track), 1);
        cyc(0, 1'b0, 1'b1);
        chk("junc_route1b", int'(ifa.track), 1);
        cyc(0, 1'b1, 1'b0);
        chk("junc_leave_pos", int'(ifa.pos), 7);
        chk("junc_leave_track", int'(ifa.track), 1);

        // Park at the end stop, then release.
        repeat (3) cyc(0, 1'b1, 1'b0);
        chk("end_pos", int'(ifa.pos), 10);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b1, 1'b0);
            chk("end_hold", int'(ifa.pos), 10);
        end
        cyc(0, 1'b0, 1'b1);
        chk("end_release_pos", int'(ifa.pos), 0);
        chk("end_keep_track", int'(ifa.track), 1);

        // Asynchronous reset mid-run.
        repeat (5) cyc(0, 1'b1, 1'b0);
        chk("mid_pos", int'(ifa.pos), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pos", int'(ifa.pos), 0);
        chk("async_track", int'(ifa.track), 0);
        chk("async_depart", int'(ifa.depart), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1'b1, 1'b0);
        chk("restart_depart", int'(ifa.depart), 1);
        cyc(0, 1'b0, 1'b0);
        chk("restart_depart_clr", int'(ifa.depart), 0);
        chk("restart_pos", int'(ifa.pos), 1);

        // Minimal geometry: junction at 1, end at 2.
        cyc(1, 1'b1, 1'b0);
        chk("b_pos1", int'(ifb.pos), 1);
        chk("b_depart", int'(ifb.depart), 1);
        chk("b_junc", int'(ifb.at_junc), 1);
        cyc(1, 1'b1, 1'b1);
        chk("b_pos2", int'(ifb.pos), 2);
        chk("b_at_end", int'(ifb.at_end), 1);
        chk("b_track_ignored", int'(ifb.track), 0);
        repeat (2) cyc(1, 1'b1, 1'b0);
        chk("b_no_overrun", int'(ifb.pos), 2);
        cyc(1, 1'b0, 1'b0);
        chk("b_idle", int'(ifb.pos), 0);
        cyc(1, 1'b1, 1'b0);
        cyc(1, 1'b0, 1'b1);
        chk("b_latch_track", int'(ifb.track), 1);
        cyc(1, 1'b1, 1'b0);
        chk("b_end_track", int'(ifb.track), 1);
        chk("b_end_pos", int'(ifb.pos), 2);

`ifdef TRAIN_SEQ_WDOG_EN
        // Watchdog trip after 8 stalled cycles; parking at END is exempt.
        repeat (3) cyc(2, 1'b1, 1'b0);
        chk("wd_pos3", int'(ifc.pos), 3);
        for (int k = 1; k <= 8; k++) begin
            cyc(2, 1'b0, 1'b0);
            chk("wd_stall_pos", int'(ifc.pos), (k < 8) ? 3 : 0);
            chk("wd_fault", int'(ifc.fault), (k < 8) ? 0 : 1);
        end
        cyc(2, 1'b0, 1'b0);
        chk("wd_fault_pulse", int'(ifc.fault), 0);
        repeat (10) cyc(2, 1'b1, 1'b0);
        chk("wd_end_pos", int'(ifc.pos), 10);
        for (int k = 0; k < 20; k++) begin
            cyc(2, 1'b1, 1'b0);
            chk("wd_end_nofault", int'(ifc.fault), 0);
        end
        chk("wd_end_hold", int'(ifc.pos), 10);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
